// File: rtl/ac_seq_mul8_ctrl.sv
// Sequencer for an 8x8 approximate product on one shared 4x4 core: issues the
// LL/LH/HL/HH nibble quadrants over four cycles and shift-accumulates the partials.
module ac_seq_mul8_ctrl #(
  parameter logic [3:0] QMODE     = 4'b0011,
  parameter bit         ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        core_en,
  output logic [3:0]  core_a,
  output logic [3:0]  core_b,
  output logic        core_sel,
  input  logic [7:0]  core_prod,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, Q_LL, Q_LH, Q_HL, Q_HH, DONE} state_t;

  state_t      state;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [16:0] acc;
  logic [16:0] addend;
  logic [16:0] acc_sum;
  logic        zero_op;

  always_comb begin
    addend = '0;
    case (state)
      Q_LL:       addend = {9'b0, core_prod};
      Q_LH, Q_HL: addend = {5'b0, core_prod, 4'b0};
      Q_HH:       addend = {1'b0, core_prod, 8'b0};
      default:    addend = '0;
    endcase
    acc_sum = acc + addend;
    zero_op = ZERO_SKIP && ((in_a == 8'h00) || (in_b == 8'h00));
  end

  // Core strobes are registered one state ahead, so they line up with the state
  // that consumes core_prod; out_prod latches the final sum and persists past DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      out_prod  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      core_en   <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
      core_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            acc      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              state     <= DONE;
              out_prod  <= '0;
              out_valid <= 1'b1;
            end else begin
              state    <= Q_LL;
              core_en  <= 1'b1;
              core_a   <= in_a[3:0];
              core_b   <= in_b[3:0];
              core_sel <= QMODE[0];
            end
          end
        end
        Q_LL: begin
          acc      <= acc_sum;
          state    <= Q_LH;
          core_a   <= a_r[3:0];
          core_b   <= b_r[7:4];
          core_sel <= QMODE[1];
        end
        Q_LH: begin
          acc      <= acc_sum;
          state    <= Q_HL;
          core_a   <= a_r[7:4];
          core_b   <= b_r[3:0];
          core_sel <= QMODE[2];
        end
        Q_HL: begin
          acc      <= acc_sum;
          state    <= Q_HH;
          core_a   <= a_r[7:4];
          core_b   <= b_r[7:4];
          core_sel <= QMODE[3];
        end
        Q_HH: begin
          acc       <= acc_sum;
          out_prod  <= acc_sum[15:0];
          state     <= DONE;
          out_valid <= 1'b1;
          core_en   <= 1'b0;
          core_a    <= '0;
          core_b    <= '0;
          core_sel  <= 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          core_en   <= 1'b0;
          core_a    <= '0;
          core_b    <= '0;
          core_sel  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_seq_mul8_ctrl.sv
// Directed plus randomized checks of ac_seq_mul8_ctrl against an arithmetic
// reference (exact or saturated 4x4 core), with a ZERO_SKIP=0 instance alongside.
module tb_ac_seq_mul8_ctrl;

  localparam logic [3:0] QM = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_prod;
  logic        core_en;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic        core_sel;
  logic [7:0]  core_prod;
  logic        busy;
  logic        wrap_mode = 1'b0;

  logic        nz_in_valid = 1'b0;
  logic        nz_in_ready;
  logic [7:0]  nz_in_a = '0;
  logic [7:0]  nz_in_b = '0;
  logic        nz_out_valid;
  logic        nz_out_ready = 1'b1;
  logic [15:0] nz_out_prod;
  logic        nz_core_en;
  logic [3:0]  nz_core_a;
  logic [3:0]  nz_core_b;
  logic        nz_core_sel;
  logic [7:0]  nz_core_prod;
  logic        nz_busy;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign core_prod    = wrap_mode ? 8'hFF : ({4'b0, core_a} * {4'b0, core_b});
  assign nz_core_prod = {4'b0, nz_core_a} * {4'b0, nz_core_b};

  ac_seq_mul8_ctrl #(.QMODE(QM), .ZERO_SKIP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .core_en(core_en), .core_a(core_a), .core_b(core_b),
    .core_sel(core_sel), .core_prod(core_prod), .busy(busy)
  );

  ac_seq_mul8_ctrl #(.QMODE(QM), .ZERO_SKIP(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
    .in_a(nz_in_a), .in_b(nz_in_b), .out_valid(nz_out_valid), .out_ready(nz_out_ready),
    .out_prod(nz_out_prod), .core_en(nz_core_en), .core_a(nz_core_a), .core_b(nz_core_b),
    .core_sel(nz_core_sel), .core_prod(nz_core_prod), .busy(nz_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [7:0] v, input bit hi);
    return hi ? v[7:4] : v[3:0];
  endfunction

  // Saturated core returns 0xFF for every quadrant: 0xFF * (1 + 16 + 16 + 256).
  function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
    if (wrap_mode) return 16'((255 * 289) % 65536);
    return 16'(int'(a) * int'(b));
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] e;
    bit zs;
    zs = (a == 8'h00) || (b == 8'h00);
    e  = exp_prod(a, b);
    chk("idle_in_ready", in_ready, 1);
    out_ready = (hold == 0);
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    if (!zs) begin
      for (int q = 0; q < 4; q++) begin
        chk("core_en", core_en, 1);
        chk("core_ab", {core_a, core_b}, {nib(a, q >= 2), nib(b, (q % 2) == 1)});
        chk("core_sel", core_sel, QM[q]);
        chk("busy_q", busy, 1);
        chk("in_ready_q", in_ready, 0);
        chk("out_valid_q", out_valid, 0);
        step();
      end
    end else begin
      chk("zs_core_en", core_en, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("out_prod", out_prod, e);
    chk("done_core_en", core_en, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_prod", out_prod, e);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("ret_out_valid", out_valid, 0);
    chk("ret_in_ready", in_ready, 1);
    chk("ret_busy", busy, 0);
    chk("ret_prod_kept", out_prod, e);
  endtask

  initial begin
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] q [$];
    int idx, acc_cnt, res_cnt, last_t, cnt;
    bit rdy_before;

    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_core", {core_en, core_a, core_b, core_sel}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // basic, zero skip, backpressure, saturated-core wrap
    do_op(8'h12, 8'h34, 0);
    chk("basic_const", out_prod, 16'h03A8);
    do_op(8'h00, 8'h55, 0);
    do_op(8'hFF, 8'hFF, 10);
    chk("bp_const", out_prod, 16'hFE01);
    wrap_mode = 1'b1;
    do_op(8'hFF, 8'hFF, 0);
    chk("wrap_const", out_prod, 16'h1FDF);
    wrap_mode = 1'b0;

    // zero operand without skip still runs all four quadrants
    nz_in_a = 8'h00; nz_in_b = 8'h55; nz_in_valid = 1'b1;
    step();
    nz_in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (nz_core_en) cnt++;
      chk("nz_not_done", nz_out_valid, 0);
      step();
    end
    chk("nz_core_cycles", cnt, 4);
    chk("nz_out_valid", nz_out_valid, 1);
    chk("nz_out_prod", nz_out_prod, 0);
    step();
    chk("nz_idle", nz_in_ready, 1);

    // reset during Q_HL
    in_a = 8'h5A; in_b = 8'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_core_en", core_en, 0);
    do_op(8'h03, 8'h05, 0);
    chk("mid_rst_const", out_prod, 16'h000F);

    // back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom_range(1, 255));
      pb[i] = 8'($urandom_range(1, 255));
    end
    idx = 0; acc_cnt = 0; res_cnt = 0; last_t = -1;
    out_ready = 1'b1;
    in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
    for (int t = 0; t < 40 && res_cnt < 3; t++) begin
      rdy_before = in_ready;
      step();
      if (rdy_before && in_valid) begin
        q.push_back(16'(int'(pa[idx]) * int'(pb[idx])));
        acc_cnt++;
        idx++;
        if (idx < 3) begin
          in_a = pa[idx]; in_b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        chk("b2b_prod", out_prod, (q.size() > 0) ? q.pop_front() : 16'hxxxx);
        if (last_t >= 0) chk("b2b_spacing", t - last_t, 6);
        last_t = t;
        res_cnt++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", res_cnt, 3);
    chk("b2b_accepts", acc_cnt, 3);
    step();

    // randomized operands, occasional zeros, random backpressure
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
